arm_dmem_responder: RTL

Memory-side responder for the 5-stage LEGv8 CPU data port: the block on the far end of `daddrbus`/`databus` that services LDUR and STUR in the CPU's MEM stage. It holds a word-addressed 64-bit data RAM, captures store data the CPU drives while `clk` is high, and drives load data while `clk` is low, matching the CPU's bus-turnaround convention. Stores are posted through a one-entry write buffer with read-after-write forwarding, so a load immediately following a store to the same word returns the new data.

---
 rtl/arm_dmem_responder_pkg.sv | 15 +
 rtl/arm_dmem_array.sv | 42 ++++
 rtl/arm_dmem_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/arm_dmem_responder_pkg.sv
// Shared widths and the posted-store write-buffer record for the LEGv8 data responder.
package arm_dmem_responder_pkg;

  localparam int DWIDTH  = 64;
  localparam int WSHIFT  = 3;
  // Index field is sized for the widest supported AW; narrower builds zero-extend into it.
  localparam int IDX_MAX = 16;

  typedef struct packed {
    logic               valid;
    logic [IDX_MAX-1:0] idx;
    logic [DWIDTH-1:0]  data;
  } wbuf_t;

endpackage

// File: rtl/arm_dmem_array.sv
// 2^AW x 64 data RAM: synchronous write, asynchronous read; optional all-zero power-up.
module arm_dmem_array
  import arm_dmem_responder_pkg::*;
#(
  parameter int AW        = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  generate
    if (INIT_ZERO) begin : g_zero
      logic [DWIDTH-1:0] mem_q [DEPTH] = '{default: '0};

      always_ff @(posedge clk) begin
        if (we) begin
          mem_q[waddr] <= wdata;
        end
      end

      assign rdata = mem_q[raddr];
    end else begin : g_noinit
      logic [DWIDTH-1:0] mem_q [DEPTH];

      always_ff @(posedge clk) begin
        if (we) begin
          mem_q[waddr] <= wdata;
        end
      end

      assign rdata = mem_q[raddr];
    end
  endgenerate

endmodule

// File: rtl/arm_dmem_responder.sv
// LEGv8 MEM-stage data responder: zero-latency loads driven in clk-low, stores posted through a one-entry buffer.
// Defining ARM_DMEM_STATS_EN adds the ld_cnt/st_cnt ports and their counters.
module arm_dmem_responder
  import arm_dmem_responder_pkg::*;
#(
  parameter int AW        = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       daddrbus,
  input  logic              mem_rd,
  input  logic              mem_wr,
  inout  wire  [DWIDTH-1:0] databus,
  output logic              err
`ifdef ARM_DMEM_STATS_EN
  ,
  output logic [31:0]       ld_cnt,
  output logic [31:0]       st_cnt
`endif
);

  localparam logic [0:0] WB_EMPTY = 1'b0;
  localparam logic [0:0] WB_FULL  = 1'b1;

  logic [AW-1:0]     idx;
  logic              bad;
  logic              is_ld;
  logic              is_st;
  logic              fwd_hit;
  logic [DWIDTH-1:0] ram_rdata;
  logic [DWIDTH-1:0] rdata;
  wbuf_t             wb_q, wb_d;
  logic              err_q, err_d;

  assign idx     = daddrbus[AW+WSHIFT-1:WSHIFT];
  assign bad     = (daddrbus[WSHIFT-1:0] != '0) || (daddrbus[63:AW+WSHIFT] != '0);
  assign is_ld   = mem_rd & ~mem_wr;
  assign is_st   = mem_wr;
  assign fwd_hit = (wb_q.valid == WB_FULL) && (wb_q.idx == IDX_MAX'(idx));

  // A store every cycle simply replaces the entry; the old one drains on the same edge.
  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = WB_EMPTY;
    if (is_st && !bad) begin
      wb_d.valid = WB_FULL;
      wb_d.idx   = IDX_MAX'(idx);
      wb_d.data  = databus;
    end
  end

  assign err_d = err_q | (bad & (mem_rd | mem_wr)) | (mem_rd & mem_wr);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // Reset suppresses the drain, so a store still sitting in the buffer is lost.
  arm_dmem_array #(
    .AW        (AW),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .clk   (clk),
    .we    (wb_q.valid & ~reset),
    .waddr (wb_q.idx[AW-1:0]),
    .wdata (wb_q.data),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    rdata = ram_rdata;
    if (bad) begin
      rdata = '0;
    end else if (fwd_hit) begin
      rdata = wb_q.data;
    end
  end

  assign databus = (~clk & is_ld & ~reset) ? rdata : {DWIDTH{1'bz}};

`ifdef ARM_DMEM_STATS_EN
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;

  assign ld_cnt_d = ld_cnt_q + {31'd0, is_ld};
  assign st_cnt_d = st_cnt_q + {31'd0, is_st & ~bad};

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign ld_cnt = ld_cnt_q;
  assign st_cnt = st_cnt_q;
`endif

endmodule
